mem_dump_reader: RTL
====================

Name: mem_dump_reader

Overview:
- Hardware reader that pairs with the transactor's front-panel deposit loader.
- Walks an address range of PDP-8 main memory over the memory-controller read handshake and captures each word.
- Streams each (address, data) pair to the host-side transactor over a valid/ready interface, so a loaded or post-run image can be dumped and compared against the source image.
- Sits on the main bus beside Front_Panel; it is only the memory initiator while busy is high.

Parameters:
- ADDR_W, 12, memory address width (PDP-8 word address).
- DATA_W, 12, memory word width.
- TIMEOUT_CYCLES, 64, maximum clk cycles to wait for mem_finished per read before aborting.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle pulse; begins a dump; ignored while busy.
- start_addr  input  ADDR_W  first address; sampled on accepted start.
- end_addr  input  ADDR_W  last address, inclusive; sampled on accepted start.
- busy  output  1  high from accepted start until done or error.
- done  output  1  one-cycle pulse at completion, including the error case.
- error  output  1  set on timeout; cleared by the next accepted start or by reset.
- word_count  output  ADDR_W+1  words delivered in the current or last dump.
- mem_read_enable  output  1  read request to the memory controller.
- mem_address  output  ADDR_W  read address.
- mem_finished  input  1  memory acknowledge (level).
- mem_read_data  input  DATA_W  read data, valid while mem_finished is high.
- mem_valid  input  1  location-valid flag, valid while mem_finished is high.
- out_valid  output  1  output word available.
- out_ready  input  1  consumer accepts the word.
- out_address  output  ADDR_W  address of the output word.
- out_data  output  DATA_W  data of the output word.
- out_last  output  1  marks the final word of the dump.

Behaviour:
- Reset values: every output is 0; the FSM is in IDLE. Asserting rst mid-dump aborts immediately, with no done pulse and no partial handshake held.
- States: IDLE, REQ, WAIT_ACK, RELEASE, SEND, FIN.
- IDLE:
  - start=1 latches cur=start_addr and end=end_addr.
  - It also clears error and word_count, sets busy=1, and goes to REQ.
- REQ (1 cycle): drive mem_address=cur and mem_read_enable=1, then go to WAIT_ACK.
- WAIT_ACK:
  - Hold mem_read_enable=1 and mem_address stable.
  - On the first cycle with mem_finished=1, capture mem_read_data and mem_valid into a holding register, drop mem_read_enable the next cycle, and go to RELEASE.
  - Per-read cycle counter: if it reaches TIMEOUT_CYCLES without mem_finished, set error=1, drop mem_read_enable, and go to FIN.
- RELEASE:
  - Wait for mem_finished=0 (four-phase handshake), then go to SEND.
  - A new request is never issued while mem_finished is still high.
  - RELEASE is not covered by the timeout.
- SEND:
  - out_valid=1 with out_address=captured address and out_data=captured data.
  - out_last=1 when cur==end.
  - All out_* signals stay stable until out_ready=1. out_ready may already be high on entry, giving a 1-cycle transfer.
  - On handshake: word_count increments.
    - If cur==end, go to FIN.
    - Otherwise cur=cur+1 modulo 2^ADDR_W and go to REQ.
- FIN (1 cycle): done=1 and busy=0 on the following cycle, then return to IDLE.
- Wrap-around: end_addr < start_addr dumps start..7777 then 0..end. start==end dumps exactly one word. The whole of memory (4096 words) is dumped with end = start-1 modulo 4096; word_count therefore needs ADDR_W+1 bits.
- Throughput floor with an immediate ack and out_ready held high: REQ, WAIT_ACK, RELEASE, SEND is 4 cycles per word.
- start arriving during busy is dropped; no queueing.
- out_valid never asserts outside SEND. mem_read_enable never asserts outside REQ/WAIT_ACK.

Optional Feature:
- SKIP_INVALID_EN defined:
  - A captured word with mem_valid=0 is not presented on the output and does not increment word_count.
  - The FSM goes RELEASE -> (cur==end ? FIN : REQ with cur+1).
  - If the last address is invalid, out_last is never seen for that word. done still pulses; the consumer uses done to terminate.
- SKIP_INVALID_EN undefined: every address in range is presented regardless of mem_valid.

Test Plan:
- Basic dump: memory 0200=7200, 0201=1205, 0202=7402. start with start_addr=0200, end_addr=0202, out_ready=1, memory acks after 2 cycles -> three words 0200/7200, 0201/1205, 0202/7402; out_last only on 0202; done 1 cycle after the last handshake; word_count=3.
- Wrap-around: start_addr=7776, end_addr=0001 -> addresses 7776, 7777, 0000, 0001 in that order; word_count=4. Single word: start_addr=end_addr=0050 -> one word with out_last=1.
- Backpressure: out_ready held low 10 cycles after out_valid rises -> out_* stable throughout; no new mem_read_enable until the handshake completes.
- Timeout: memory never asserts mem_finished -> after 64 cycles error=1, done pulse, busy=0, mem_read_enable=0, no out_valid. A following start clears error.
- Reset mid-dump: assert rst during WAIT_ACK of the 2nd word -> all outputs 0 immediately, no done pulse. A fresh start afterwards dumps correctly from start_addr.
- SKIP_INVALID_EN: range 0100..0103 with 0101 invalid -> outputs only 0100, 0102, 0103; word_count=3. Without the macro -> 4 words including 0101.

Source files
------------

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks PDP-8 memory from start_addr to end_addr (inclusive,
// wrapping modulo 2^ADDR_W) over the four-phase memory read handshake. Each
// (address, data) pair is streamed to the host over a valid/ready port.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start               pulse that begins a dump; ignored while busy
//   start_addr/end_addr inclusive range, sampled on an accepted start
//   busy/done/error     status: done pulses at completion, error on timeout
//   word_count          words delivered in the current or last dump
//   mem_*               memory-controller read initiator side
//   out_*               valid/ready output stream, out_last on the final word
//
// Build option: define SKIP_INVALID_EN to drop words whose mem_valid was 0.
// Those words are not presented and not counted.
module mem_dump_reader #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_address,
    input  logic              mem_finished,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_address,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, RELEASE, SEND, FIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cur, end_r;
    logic [DATA_W-1:0] hold_data;
    logic [TW-1:0]     tmo;
    logic              error_r;
    logic [ADDR_W:0]   word_count_r;
    logic              at_end;
    logic              tmo_hit;

`ifdef SKIP_INVALID_EN
    logic hold_valid;
`else
    // Location-valid flag only matters when invalid words are skipped.
    logic unused_mem_valid;
    assign unused_mem_valid = mem_valid;
`endif

    assign at_end  = (cur == end_r);
    // The counter starts at 0 on the first WAIT_ACK cycle, so hitting
    // TIMEOUT_CYCLES-1 without an ack means TIMEOUT_CYCLES cycles waited.
    assign tmo_hit = (tmo == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = REQ;
            REQ:      state_nx = WAIT_ACK;
            WAIT_ACK: begin
                if (mem_finished) state_nx = RELEASE;
                else if (tmo_hit) state_nx = FIN;
            end
            // Wait for the controller to drop its ack before any new request.
            RELEASE: begin
                if (!mem_finished) begin
`ifdef SKIP_INVALID_EN
                    if (!hold_valid) state_nx = at_end ? FIN : REQ;
                    else             state_nx = SEND;
`else
                    state_nx = SEND;
`endif
                end
            end
            SEND:     if (out_ready) state_nx = at_end ? FIN : REQ;
            FIN:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cur          <= '0;
            end_r        <= '0;
            hold_data    <= '0;
            tmo          <= '0;
            error_r      <= 1'b0;
            word_count_r <= '0;
`ifdef SKIP_INVALID_EN
            hold_valid   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    cur          <= start_addr;
                    end_r        <= end_addr;
                    error_r      <= 1'b0;
                    word_count_r <= '0;
                end
                REQ: tmo <= '0;
                WAIT_ACK: begin
                    tmo <= tmo + TW'(1);
                    if (mem_finished) begin
                        hold_data  <= mem_read_data;
`ifdef SKIP_INVALID_EN
                        hold_valid <= mem_valid;
`endif
                    end else if (tmo_hit) begin
                        error_r <= 1'b1;
                    end
                end
`ifdef SKIP_INVALID_EN
                RELEASE: if (!mem_finished && !hold_valid && !at_end)
                    cur <= cur + ADDR_W'(1);
`endif
                SEND: if (out_ready) begin
                    word_count_r <= word_count_r + (ADDR_W+1)'(1);
                    if (!at_end) cur <= cur + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state, so reset clears them immediately.
    assign busy            = (state != IDLE);
    assign done            = (state == FIN);
    assign error           = error_r;
    assign word_count      = word_count_r;
    assign mem_read_enable = (state == REQ) || (state == WAIT_ACK);
    assign mem_address     = mem_read_enable ? cur : '0;
    assign out_valid       = (state == SEND);
    assign out_address     = out_valid ? cur : '0;
    assign out_data        = out_valid ? hold_data : '0;
    assign out_last        = out_valid && at_end;

endmodule
